// File: rtl/ahb_sub_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ahb_sub_mem
//  Purpose  : AHB-Lite subordinate wrapping a word-organised scratch RAM.
//             Inserts a programmable number of wait states on OKAY data
//             phases and returns a two-cycle ERROR response for out-of-range,
//             misaligned or non-word transfers.
//  Ports    : ACLK / ARESETN      clock, asynchronous active-low reset
//             HSEL, HADDR, HTRANS,
//             HWRITE, HSIZE,
//             HBURST, HREADY      address-phase inputs (HBURST not decoded)
//             HWDATA              write data, valid in the data phase
//             HREADYOUT, HRESP,
//             HRDATA              registered data-phase response
//  Revision : 1.0  initial release
// ============================================================================
module ahb_sub_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA
);

    localparam int c_idx_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_aidx_w = ADDR_WIDTH - 2;
    // DEPTH widened by one bit so the range test never wraps.
    localparam logic [c_aidx_w:0] c_depth_ext = (c_aidx_w + 1)'(DEPTH);
    localparam logic [3:0]        c_wait_load = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [c_idx_w-1:0]   idx_q;
    logic                 write_q;

    logic [31:0]          mem [DEPTH];

    logic [c_aidx_w-1:0]  w_idx_full;
    logic [c_idx_w-1:0]   w_idx;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_wr_commit;
    logic [31:0]          w_rd_data;

    // HBURST is informational and HTRANS[0] only separates NONSEQ from SEQ,
    // which are treated alike.
    logic                 unused_inputs;
    assign unused_inputs = ^{HBURST, HTRANS[0]};

    assign w_idx_full = HADDR[ADDR_WIDTH-1:2];
    assign w_idx      = w_idx_full[c_idx_w-1:0];
    assign w_err      = ({1'b0, w_idx_full} >= c_depth_ext)
                     || (HSIZE != 3'b010)
                     || (HADDR[1:0] != 2'b00);

    // A new address phase can only be taken while this subordinate is not
    // stalling its own data phase (HREADYOUT high in IDLE, DATA and ERR2).
    assign w_accept    = HSEL && HTRANS[1] && HREADY && HREADYOUT;
    assign w_wr_commit = (state_q == S_DATA) && write_q;

    // Read-after-write forwarding: the write completing on this edge has not
    // reached the array yet, so take its data straight from the bus.
    assign w_rd_data = (w_wr_commit && (idx_q == w_idx)) ? HWDATA : mem[w_idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all accept a new transfer the same way.
                if (w_accept) begin
                    if (w_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = c_wait_load;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            HREADYOUT <= (state_d != S_WAIT) && (state_d != S_ERR1);
            HRESP     <= (state_d == S_ERR1) || (state_d == S_ERR2);
            // Errored transfers leave the latched index, direction and
            // HRDATA untouched; they never reach DATA so never write.
            if (w_accept && !w_err) begin
                idx_q   <= w_idx;
                write_q <= HWRITE;
                if (!HWRITE) begin
                    HRDATA <= w_rd_data;
                end
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge ACLK) begin
        if (w_wr_commit) begin
            mem[idx_q] <= HWDATA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sub_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_sub_mem
//  Purpose  : Self-checking bench for ahb_sub_mem. Three instances with
//             WAIT_STATES = 0, 2 and 3 are driven by a pipelined AHB manager
//             model; a transaction-level reference predicts the response of
//             every cycle and a compare process checks all outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_sub_mem;

    localparam int NI    = 3;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic rdy;
        logic resp;
    } exp_t;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [7:0]  addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } item_t;

    localparam item_t IDLE_ITEM = '{sel: 1'b0, trans: 2'b00, wr: 1'b0,
                                    addr: 8'h00, size: 3'b010, wdata: 32'h0};

    logic        clk;
    logic        rstn      [NI];
    logic        hsel      [NI];
    logic [7:0]  haddr     [NI];
    logic [1:0]  htrans    [NI];
    logic        hwrite    [NI];
    logic [2:0]  hsize     [NI];
    logic [2:0]  hburst    [NI];
    logic [31:0] hwdata    [NI];
    logic        hready    [NI];
    logic        hreadyout [NI];
    logic        hresp     [NI];
    logic [31:0] hrdata    [NI];

    for (genvar gk = 0; gk < NI; gk++) begin : g_dut
        assign hready[gk] = hreadyout[gk];
        ahb_sub_mem #(
            .ADDR_WIDTH (8),
            .DEPTH      (DEPTH),
            .WAIT_STATES(gk == 0 ? 0 : gk + 1)
        ) u_dut (
            .ACLK     (clk),
            .ARESETN  (rstn[gk]),
            .HSEL     (hsel[gk]),
            .HADDR    (haddr[gk]),
            .HTRANS   (htrans[gk]),
            .HWRITE   (hwrite[gk]),
            .HSIZE    (hsize[gk]),
            .HBURST   (hburst[gk]),
            .HWDATA   (hwdata[gk]),
            .HREADY   (hready[gk]),
            .HREADYOUT(hreadyout[gk]),
            .HRESP    (hresp[gk]),
            .HRDATA   (hrdata[gk])
        );
    end

    // Reference state
    item_t       txq       [NI][$];
    exp_t        expq      [NI][$];
    item_t       cur       [NI];
    logic [31:0] mdl_mem   [NI][DEPTH];
    logic [31:0] exp_rdata [NI];
    logic        hr_edge   [NI];
    int          stall_cnt [NI];
    int          resp_cnt  [NI];
    int          acc_cnt   [NI];
    int          n_cmp;
    int          n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %h, expected %h", name, k, $time, act, exp);
        end
    endtask

    // What an accepted transfer must produce, straight from the protocol
    // rules: ERROR takes two cycles, OKAY takes WAIT_STATES+1, transfers
    // complete in order so memory can be updated at acceptance.
    task automatic model_accept(input int k, input item_t it);
        int idx;
        bit err;
        idx = int'(it.addr[7:2]);
        err = (idx >= DEPTH) || (it.size != 3'b010) || (it.addr[1:0] != 2'b00);
        acc_cnt[k]++;
        stall_cnt[k] = 0;
        resp_cnt[k]  = 0;
        if (err) begin
            expq[k].push_back(exp_t'{1'b0, 1'b1});
            expq[k].push_back(exp_t'{1'b1, 1'b1});
        end else begin
            repeat (ws_of(k)) expq[k].push_back(exp_t'{1'b0, 1'b0});
            expq[k].push_back(exp_t'{1'b1, 1'b0});
            if (it.wr) mdl_mem[k][idx] = it.wdata;
            else       exp_rdata[k]    = mdl_mem[k][idx];
        end
    endtask

    task automatic drive(input int k);
        hsel[k]   = cur[k].sel;
        htrans[k] = cur[k].trans;
        hwrite[k] = cur[k].wr;
        haddr[k]  = cur[k].addr;
        hsize[k]  = cur[k].size;
        hburst[k] = 3'($urandom_range(0, 7));
    endtask

    // Manager: address phase advances only on an edge where HREADY was high.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NI; k++) begin
            if (!rstn[k]) begin
                cur[k] = IDLE_ITEM;
            end else if (hr_edge[k]) begin
                if (cur[k].sel && cur[k].trans[1]) begin
                    model_accept(k, cur[k]);
                    hwdata[k] = cur[k].wr ? cur[k].wdata : $urandom;
                end
                cur[k] = (txq[k].size() > 0) ? txq[k].pop_front() : IDLE_ITEM;
            end
            drive(k);
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            e = (expq[k].size() > 0) ? expq[k].pop_front() : exp_t'{1'b1, 1'b0};
            chk("HREADYOUT", k, 32'(hreadyout[k]), 32'(e.rdy));
            chk("HRESP",     k, 32'(hresp[k]),     32'(e.resp));
            chk("HRDATA",    k, hrdata[k],         exp_rdata[k]);
            hr_edge[k] = hreadyout[k];
            if (!hreadyout[k]) stall_cnt[k]++;
            if (hresp[k])      resp_cnt[k]++;
        end
    end

    task automatic push(input int k, input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [7:0] a, input logic [2:0] sz, input logic [31:0] d);
        item_t it;
        it.sel = sel; it.trans = tr; it.wr = wr; it.addr = a; it.size = sz; it.wdata = d;
        txq[k].push_back(it);
    endtask

    task automatic wr(input int k, input logic [1:0] tr, input logic [7:0] a, input logic [31:0] d);
        push(k, 1'b1, tr, 1'b1, a, 3'b010, d);
    endtask

    task automatic rd(input int k, input logic [1:0] tr, input logic [7:0] a);
        push(k, 1'b1, tr, 1'b0, a, 3'b010, $urandom);
    endtask

    task automatic drain(input int k);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (txq[k].size() == 0 && !(cur[k].sel && cur[k].trans[1]) && expq[k].size() == 0)
                break;
        end
        chk("drain_done", k, 32'(i < 400), 32'd1);
    endtask

    task automatic rand_item(input int k);
        int          r;
        logic        sel;
        logic [1:0]  tr;
        logic [7:0]  a;
        logic [2:0]  sz;
        r   = $urandom_range(0, 99);
        sel = 1'b1;
        tr  = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
        a   = {1'b0, 5'($urandom_range(0, DEPTH - 1)), 2'b00};
        sz  = 3'b010;
        if (r < 6) begin
            sel = 1'b0;
            tr  = 2'($urandom_range(0, 3));
        end else if (r < 10) tr = 2'b00;
        else if (r < 14)     tr = 2'b01;
        else if (r < 17)     a[7] = 1'b1;
        else if (r < 20)     sz = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b011;
        else if (r < 23)     a[1:0] = 2'($urandom_range(1, 3));
        push(k, sel, tr, 1'($urandom_range(0, 1)), a, sz, $urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int a0;
        n_cmp = 0;
        n_bad = 0;
        for (int k = 0; k < NI; k++) begin
            rstn[k]      = 1'b0;
            cur[k]       = IDLE_ITEM;
            hr_edge[k]   = 1'b1;
            exp_rdata[k] = 32'h0;
            stall_cnt[k] = 0;
            resp_cnt[k]  = 0;
            acc_cnt[k]   = 0;
            hwdata[k]    = 32'h0;
            drive(k);
        end
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("reset_HREADYOUT", k, 32'(hreadyout[k]), 32'd1);
            chk("reset_HRESP",     k, 32'(hresp[k]),     32'd0);
            chk("reset_HRDATA",    k, hrdata[k],         32'h0);
        end
        #1;
        for (int k = 0; k < NI; k++) rstn[k] = 1'b1;

        // ---- zero wait states: basic write/read, forwarding, errors, burst
        wr(0, 2'b10, 8'h00, 32'h0C0C0C0C);
        wr(0, 2'b10, 8'h10, 32'hDEADBEEF);
        rd(0, 2'b10, 8'h10);
        drain(0);
        chk("ws0_read_data",  0, hrdata[0], 32'hDEADBEEF);
        chk("ws0_read_stall", 0, 32'(stall_cnt[0]), 32'd0);

        wr(0, 2'b10, 8'h08, 32'hA5A5A5A5);
        rd(0, 2'b10, 8'h08);
        drain(0);
        chk("fwd_read_data", 0, hrdata[0], 32'hA5A5A5A5);

        wr(0, 2'b10, 8'h80, 32'hFFFFFFFF);
        drain(0);
        chk("err_wr_stall", 0, 32'(stall_cnt[0]), 32'd1);
        chk("err_wr_resp",  0, 32'(resp_cnt[0]),  32'd2);
        chk("err_wr_hold",  0, hrdata[0], 32'hA5A5A5A5);
        push(0, 1'b1, 2'b10, 1'b0, 8'h00, 3'b001, 32'h0);
        drain(0);
        chk("err_rd_stall", 0, 32'(stall_cnt[0]), 32'd1);
        chk("err_rd_resp",  0, 32'(resp_cnt[0]),  32'd2);
        chk("err_rd_hold",  0, hrdata[0], 32'hA5A5A5A5);
        rd(0, 2'b10, 8'h00);
        drain(0);
        chk("idx0_intact", 0, hrdata[0], 32'h0C0C0C0C);

        wr(0, 2'b10, 8'h00, 32'h1);
        wr(0, 2'b11, 8'h04, 32'h2);
        push(0, 1'b1, 2'b01, 1'b1, 8'h08, 3'b010, 32'h0);
        wr(0, 2'b11, 8'h08, 32'h3);
        wr(0, 2'b11, 8'h0C, 32'h4);
        drain(0);
        for (int i = 0; i < 4; i++) begin
            rd(0, (i == 0) ? 2'b10 : 2'b11, 8'(4 * i));
            drain(0);
            chk("burst_readback", 0, hrdata[0], 32'(i + 1));
        end

        // ---- two wait states
        wr(1, 2'b10, 8'h04, 32'h12345678);
        drain(1);
        rd(1, 2'b10, 8'h04);
        drain(1);
        chk("ws2_read_data",  1, hrdata[1], 32'h12345678);
        chk("ws2_read_stall", 1, 32'(stall_cnt[1]), 32'd2);
        chk("ws2_read_resp",  1, 32'(resp_cnt[1]),  32'd0);

        // ---- three wait states, reset in the second wait cycle
        wr(2, 2'b10, 8'h0C, 32'h0BADF00D);
        drain(2);
        a0 = acc_cnt[2];
        rd(2, 2'b10, 8'h0C);
        for (int i = 0; i < 50 && acc_cnt[2] == a0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("rst_read_accepted", 2, 32'(acc_cnt[2] != a0), 32'd1);
        @(posedge clk);
        #2;
        rstn[2] = 1'b0;
        expq[2].delete();
        exp_rdata[2] = 32'h0;
        #1;
        chk("midrst_HREADYOUT", 2, 32'(hreadyout[2]), 32'd1);
        chk("midrst_HRESP",     2, 32'(hresp[2]),     32'd0);
        chk("midrst_HRDATA",    2, hrdata[2],         32'h0);
        @(negedge clk);
        #2;
        rstn[2] = 1'b1;
        rd(2, 2'b10, 8'h0C);
        drain(2);
        chk("post_rst_data",  2, hrdata[2], 32'h0BADF00D);
        chk("post_rst_stall", 2, 32'(stall_cnt[2]), 32'd3);

        // ---- randomized traffic on all instances
        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < DEPTH; w++) wr(k, 2'b10, 8'(4 * w), $urandom);
            for (int n = 0; n < 200; n++) rand_item(k);
        end
        for (int k = 0; k < NI; k++) drain(k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
